gp_reg_write_seq: RTL and testbench

//  Write-side sequencer for the gp_reg_b register bank: accepts write requests (index+data)

---
 rtl/gp_reg_write_seq_if.sv | 24 ++
 rtl/gp_reg_write_seq.sv | 106 ++++++++++
 tb/tb_gp_reg_write_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gp_reg_write_seq_if.sv
// gp_reg_write_seq_if: request handshake and register-bank bus of the write sequencer
// master: decode side (drives req_*, observes status and bus)
// slave : sequencer side (accepts req_*, drives req_ready, di, di_oe, w_clk, reg_n_rst, busy, err)
interface gp_reg_write_seq_if #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_data;
  logic              req_clear;
  logic [DATA_W-1:0] di;
  logic              di_oe;
  logic [NUM_REGS-1:0] w_clk;
  logic              reg_n_rst;
  logic              busy;
  logic              err;
  modport master (output req_valid, req_idx, req_data, req_clear,
                  input  req_ready, di, di_oe, w_clk, reg_n_rst, busy, err);
  modport slave  (input  req_valid, req_idx, req_data, req_clear,
                  output req_ready, di, di_oe, w_clk, reg_n_rst, busy, err);
endinterface

// File: rtl/gp_reg_write_seq.sv
// gp_reg_write_seq: queues register write/clear requests and sequences TTL-safe write cycles
// clk   : system clock, rising edge
// n_rst : synchronous active-low reset
// bus   : slave side of gp_reg_write_seq_if (req_* handshake in, di/di_oe/w_clk/reg_n_rst/busy/err out)
module gp_reg_write_seq #(
  parameter int NUM_REGS     = 4,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input logic clk,
  input logic n_rst,
  gp_reg_write_seq_if.slave bus
);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = 1 + IDX_W + DATA_W;
  localparam int MAXC  = SETUP_CYCLES > HOLD_CYCLES ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;
  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wp, r_rp;
  logic                r_init;
  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_clr;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_di;
  logic                r_di_oe;
  logic [NUM_REGS-1:0] r_w_clk;
  logic                r_reg_n_rst;
  logic                r_err;
  logic                w_empty, w_full, w_valid_idx, w_acc, w_push, w_pop;
  logic                w_setup_done, w_hold_done;
  logic [EW-1:0]       w_head;
  assign w_empty      = r_wp == r_rp;
  assign w_full       = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_valid_idx  = 32'(bus.req_idx) < NUM_REGS;
  assign w_acc        = bus.req_valid & bus.req_ready;
  assign w_push       = w_acc & (bus.req_clear | w_valid_idx);
  assign w_setup_done = r_cnt == CW'(SETUP_CYCLES - 1);
  assign w_hold_done  = r_cnt == CW'(HOLD_CYCLES - 1);
  // Pop only when the bus is free: from IDLE, or at the end of HOLD for back-to-back cycles
  assign w_pop        = !w_empty & ((r_state == S_IDLE) | ((r_state == S_HOLD) & w_hold_done));
  assign w_head       = r_mem[r_rp[AW-1:0]];
  // r_init holds ready low for the cycle following a reset edge
  assign bus.req_ready = r_init & !w_full;
  assign bus.di        = r_di;
  assign bus.di_oe     = r_di_oe;
  assign bus.w_clk     = r_w_clk;
  assign bus.reg_n_rst = r_reg_n_rst;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != S_IDLE) | !w_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {bus.req_clear, bus.req_idx, bus.req_data};
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_init      <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_clr       <= 1'b0;
      r_idx       <= '0;
      r_di        <= '0;
      r_di_oe     <= 1'b0;
      r_w_clk     <= '0;
      r_reg_n_rst <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_init <= 1'b1;
      r_err  <= w_acc & !bus.req_clear & !w_valid_idx;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp    <= r_rp + 1'b1;
        r_state <= S_SETUP;
        r_cnt   <= '0;
        r_clr   <= w_head[EW-1];
        r_idx   <= w_head[DATA_W +: IDX_W];
        r_di    <= w_head[EW-1] ? '0 : w_head[DATA_W-1:0];
        r_di_oe <= !w_head[EW-1];
      end else if (r_state == S_SETUP) begin
        if (w_setup_done) begin
          r_state     <= S_STROBE;
          r_w_clk     <= r_clr ? '0 : NUM_REGS'(1) << r_idx;
          r_reg_n_rst <= !r_clr;
        end else r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_STROBE) begin
        r_state     <= S_HOLD;
        r_cnt       <= '0;
        r_w_clk     <= '0;
        r_reg_n_rst <= 1'b1;
      end else if (r_state == S_HOLD) begin
        if (w_hold_done) begin
          r_state <= S_IDLE;
          r_di    <= '0;
          r_di_oe <= 1'b0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gp_reg_write_seq.sv
// tb_gp_reg_write_seq: directed self-checking bench for gp_reg_write_seq (three parameter builds)
module tb_gp_reg_write_seq;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  gp_reg_write_seq_if a ();
  gp_reg_write_seq_if #(.NUM_REGS(3)) b ();
  gp_reg_write_seq_if c ();
  gp_reg_write_seq u_a (.clk(clk), .n_rst(n_rst), .bus(a));
  gp_reg_write_seq #(.NUM_REGS(3)) u_b (.clk(clk), .n_rst(n_rst), .bus(b));
  gp_reg_write_seq #(.SETUP_CYCLES(2), .HOLD_CYCLES(3)) u_c (.clk(clk), .n_rst(n_rst), .bus(c));
  logic [7:0] mdl [4];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!a.reg_n_rst) mdl[i] <= 8'h00;
      else if (a.w_clk[i]) mdl[i] <= a.di;
  logic [3:0] t2_w  [9] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
  logic [7:0] t2_d  [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h00};
  logic       t2_r  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] t3_w  [6] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       t3_rn [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       t3_oe [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] t3_d  [6] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] t6_w  [7] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       t6_oe [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] t6_d  [7] = '{8'h9A, 8'h9A, 8'h9A, 8'h9A, 8'h9A, 8'h9A, 8'h00};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    {a.req_valid, a.req_clear, a.req_idx, a.req_data} = '0;
    {b.req_valid, b.req_clear, b.req_idx, b.req_data} = '0;
    {c.req_valid, c.req_clear, c.req_idx, c.req_data} = '0;
    tick();
    chk("rst_ready", a.req_ready, 0);
    chk("rst_di", a.di, 0);
    chk("rst_di_oe", a.di_oe, 0);
    chk("rst_w_clk", a.w_clk, 0);
    chk("rst_reg_n_rst", a.reg_n_rst, 1);
    chk("rst_busy", a.busy, 0);
    chk("rst_err", a.err, 0);
    n_rst = 1'b1;
    tick();
    chk("ready_after_rst", a.req_ready, 1);
    a.req_valid = 1'b1; a.req_idx = 2'd2; a.req_data = 8'hA5;
    tick();
    a.req_valid = 1'b0;
    chk("t1_busy_n0", a.busy, 1);
    chk("t1_oe_n0", a.di_oe, 0);
    tick();
    chk("t1_di_n1", a.di, 8'hA5);
    chk("t1_oe_n1", a.di_oe, 1);
    chk("t1_wclk_n1", a.w_clk, 0);
    tick();
    chk("t1_wclk_n2", a.w_clk, 4'b0100);
    chk("t1_di_n2", a.di, 8'hA5);
    tick();
    chk("t1_wclk_n3", a.w_clk, 0);
    chk("t1_di_n3", a.di, 8'hA5);
    chk("t1_oe_n3", a.di_oe, 1);
    tick();
    chk("t1_oe_n4", a.di_oe, 0);
    chk("t1_di_n4", a.di, 0);
    chk("t1_busy_n4", a.busy, 0);
    chk("t1_model2", mdl[2], 8'hA5);
    a.req_valid = 1'b1; a.req_idx = 2'd0; a.req_data = 8'h11;
    tick();
    a.req_idx = 2'd1; a.req_data = 8'h22;
    tick();
    chk("t2_ready_3rd", a.req_ready, 1);
    a.req_idx = 2'd3; a.req_data = 8'h33;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t2_wclk_%0d", i), a.w_clk, t2_w[i]);
      chk($sformatf("t2_di_%0d", i), a.di, t2_d[i]);
      chk($sformatf("t2_ready_%0d", i), a.req_ready, t2_r[i]);
      if (i == 0) begin a.req_idx = 2'd2; a.req_data = 8'h44; end
      if (i == 1) a.req_valid = 1'b0;
    end
    chk("t2_model0", mdl[0], 8'h11);
    chk("t2_model1", mdl[1], 8'h22);
    chk("t2_model3", mdl[3], 8'h33);
    chk("t2_model2_refused", mdl[2], 8'hA5);
    a.req_valid = 1'b1; a.req_idx = 2'd1; a.req_data = 8'h3C;
    tick();
    a.req_clear = 1'b1;
    tick();
    a.req_valid = 1'b0; a.req_clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_wclk_%0d", i), a.w_clk, t3_w[i]);
      chk($sformatf("t3_nrst_%0d", i), a.reg_n_rst, t3_rn[i]);
      chk($sformatf("t3_oe_%0d", i), a.di_oe, t3_oe[i]);
      chk($sformatf("t3_di_%0d", i), a.di, t3_d[i]);
      if (i == 2) chk("t3_model1_written", mdl[1], 8'h3C);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t3_cleared_%0d", i), mdl[i], 0);
    chk("t3_busy_end", a.busy, 0);
    b.req_valid = 1'b1; b.req_idx = 2'd3; b.req_data = 8'h77;
    tick();
    b.req_valid = 1'b0;
    chk("t4_err", b.err, 1);
    chk("t4_busy", b.busy, 0);
    chk("t4_wclk", b.w_clk, 0);
    tick();
    chk("t4_err_pulse", b.err, 0);
    chk("t4_busy2", b.busy, 0);
    chk("t4_oe2", b.di_oe, 0);
    b.req_valid = 1'b1; b.req_clear = 1'b1;
    tick();
    b.req_valid = 1'b0; b.req_clear = 1'b0;
    chk("t4_clear_no_err", b.err, 0);
    chk("t4_clear_busy", b.busy, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_drained", b.busy, 0);
    a.req_valid = 1'b1; a.req_idx = 2'd0; a.req_data = 8'h55;
    tick();
    a.req_idx = 2'd1; a.req_data = 8'h66;
    tick();
    a.req_valid = 1'b0;
    tick();
    chk("t5_strobe", a.w_clk, 4'b0001);
    chk("t5_busy_pre", a.busy, 1);
    n_rst = 1'b0;
    tick();
    chk("t5_wclk", a.w_clk, 0);
    chk("t5_oe", a.di_oe, 0);
    chk("t5_busy", a.busy, 0);
    chk("t5_ready", a.req_ready, 0);
    chk("t5_nrst_out", a.reg_n_rst, 1);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t5_quiet_%0d", i), a.w_clk, 0);
      chk($sformatf("t5_idle_%0d", i), a.busy, 0);
    end
    chk("t5_model0", mdl[0], 8'h55);
    chk("t5_model1", mdl[1], 8'h00);
    c.req_valid = 1'b1; c.req_idx = 2'd1; c.req_data = 8'h9A;
    tick();
    c.req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t6_wclk_%0d", i), c.w_clk, t6_w[i]);
      chk($sformatf("t6_oe_%0d", i), c.di_oe, t6_oe[i]);
      chk($sformatf("t6_di_%0d", i), c.di, t6_d[i]);
    end
    chk("t6_busy_end", c.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
